// File: rtl/axi4_bus_wr_fifo.sv
// AXI4 write-path buffer: independent first-word-fall-through FIFOs on AW, W and B,
// with an outstanding-write counter that throttles AW acceptance.

module axi4_bus_wr_fifo_chan #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             in_ready
);

  localparam int AB = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AB:0]      wr_ptr, rd_ptr;
  logic [AB:0]      wr_nxt, rd_nxt;
  logic             do_push, do_pop;
  logic             full_nxt;

  assign full  = (wr_ptr[AB-1:0] == rd_ptr[AB-1:0]) && (wr_ptr[AB] != rd_ptr[AB]);
  assign empty = (wr_ptr == rd_ptr);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign wr_nxt   = wr_ptr + (AB+1)'(do_push);
  assign rd_nxt   = rd_ptr + (AB+1)'(do_pop);
  assign full_nxt = (wr_nxt[AB-1:0] == rd_nxt[AB-1:0]) && (wr_nxt[AB] != rd_nxt[AB]);

  // Input ready is registered from the next occupancy, so it is low in reset and
  // never depends combinationally on the output-side ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      in_ready <= !full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AB-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AB-1:0]];

endmodule

module axi4_bus_wr_fifo #(
  parameter int A               = 32,
  parameter int N               = 8,
  parameter int I               = 1,
  parameter int AW_DEPTH        = 4,
  parameter int W_DEPTH         = 16,
  parameter int B_DEPTH         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [I-1:0]   s_awid,
  input  logic [A-1:0]   s_awaddr,
  input  logic [7:0]     s_awlen,
  input  logic [2:0]     s_awsize,
  input  logic [1:0]     s_awburst,
  input  logic           s_awvalid,
  output logic           s_awready,
  input  logic [8*N-1:0] s_wdata,
  input  logic [N-1:0]   s_wstrb,
  input  logic           s_wlast,
  input  logic           s_wvalid,
  output logic           s_wready,
  output logic [I-1:0]   s_bid,
  output logic [1:0]     s_bresp,
  output logic           s_bvalid,
  input  logic           s_bready,
  output logic [I-1:0]   m_awid,
  output logic [A-1:0]   m_awaddr,
  output logic [7:0]     m_awlen,
  output logic [2:0]     m_awsize,
  output logic [1:0]     m_awburst,
  output logic           m_awvalid,
  input  logic           m_awready,
  output logic [8*N-1:0] m_wdata,
  output logic [N-1:0]   m_wstrb,
  output logic           m_wlast,
  output logic           m_wvalid,
  input  logic           m_wready,
  input  logic [I-1:0]   m_bid,
  input  logic [1:0]     m_bresp,
  input  logic           m_bvalid,
  output logic           m_bready,
  output logic           aw_wr_full,
  output logic           aw_rd_empty,
  output logic           w_wr_full,
  output logic           w_rd_empty,
  output logic           b_wr_full,
  output logic           b_rd_empty,
  output logic [7:0]     outstanding
);

  localparam int AWW = I + A + 8 + 3 + 2;
  localparam int WW  = 8*N + N + 1;
  localparam int BW  = I + 2;
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

  logic [AWW-1:0] aw_din, aw_dout;
  logic [WW-1:0]  w_din, w_dout;
  logic [BW-1:0]  b_din, b_dout;
  logic           aw_in_ready, w_in_ready, b_in_ready;
  logic           aw_push, aw_pop, w_push, w_pop, b_push, b_pop;
  logic [7:0]     cnt, cnt_nxt;

  assign aw_din = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst};
  assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst} = aw_dout;
  assign w_din  = {s_wdata, s_wstrb, s_wlast};
  assign {m_wdata, m_wstrb, m_wlast} = w_dout;
  assign b_din  = {m_bid, m_bresp};
  assign {s_bid, s_bresp} = b_dout;

  assign s_awready = aw_in_ready && (cnt != MAX_CNT);
  assign s_wready  = w_in_ready;
  assign m_bready  = b_in_ready;

  assign m_awvalid = !aw_rd_empty;
  assign m_wvalid  = !w_rd_empty;
  assign s_bvalid  = !b_rd_empty;

  assign aw_push = s_awvalid && s_awready;
  assign aw_pop  = m_awvalid && m_awready;
  assign w_push  = s_wvalid && s_wready;
  assign w_pop   = m_wvalid && m_wready;
  assign b_push  = m_bvalid && m_bready;
  assign b_pop   = s_bvalid && s_bready;

  axi4_bus_wr_fifo_chan #(.WIDTH(AWW), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk      (aclk),
    .rst_n    (aresetn),
    .push     (aw_push),
    .pop      (aw_pop),
    .din      (aw_din),
    .dout     (aw_dout),
    .full     (aw_wr_full),
    .empty    (aw_rd_empty),
    .in_ready (aw_in_ready)
  );

  axi4_bus_wr_fifo_chan #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk      (aclk),
    .rst_n    (aresetn),
    .push     (w_push),
    .pop      (w_pop),
    .din      (w_din),
    .dout     (w_dout),
    .full     (w_wr_full),
    .empty    (w_rd_empty),
    .in_ready (w_in_ready)
  );

  axi4_bus_wr_fifo_chan #(.WIDTH(BW), .DEPTH(B_DEPTH)) u_b_fifo (
    .clk      (aclk),
    .rst_n    (aresetn),
    .push     (b_push),
    .pop      (b_pop),
    .din      (b_din),
    .dout     (b_dout),
    .full     (b_wr_full),
    .empty    (b_rd_empty),
    .in_ready (b_in_ready)
  );

  // Saturating at zero: a response with nothing outstanding is ignored by the count.
  always_comb begin
    cnt_nxt = cnt;
    if (aw_push && !b_pop)
      cnt_nxt = cnt + 8'd1;
    else if (b_pop && !aw_push && (cnt != 8'd0))
      cnt_nxt = cnt - 8'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt <= 8'd0;
    else          cnt <= cnt_nxt;
  end

  assign outstanding = cnt;

`ifndef SYNTHESIS
  b_without_outstanding : assert property (@(posedge aclk) disable iff (!aresetn)
    !(b_pop && !aw_push && (cnt == 8'd0)));
`endif

endmodule

// File: tb/tb_axi4_bus_wr_fifo.sv
// Directed bench for axi4_bus_wr_fifo: reset, single beat, fill/drain, outstanding
// throttle, full-with-pop, mid-burst reset and a throttled W-channel scoreboard run.

module tb_axi4_bus_wr_fifo;

  logic        aclk;
  logic        aresetn;
  logic [0:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid;
  logic        s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready;
  logic [0:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [0:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready;
  logic [0:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic        aw_wr_full, aw_rd_empty, w_wr_full, w_rd_empty, b_wr_full, b_rd_empty;
  logic [7:0]  outstanding;

  int compared = 0;
  int mismatched = 0;

  axi4_bus_wr_fifo dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .aw_wr_full(aw_wr_full), .aw_rd_empty(aw_rd_empty),
    .w_wr_full(w_wr_full), .w_rd_empty(w_rd_empty),
    .b_wr_full(b_wr_full), .b_rd_empty(b_rd_empty),
    .outstanding(outstanding)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  localparam int NRAND = 2000;

  logic [72:0] q[$];
  logic [72:0] beat, prevData;
  logic        prevHold, doPush, doPop;
  int          sent, rcvd;
  logic [7:0]  b8;
  logic [0:0]  bidTab [5];
  logic [1:0]  brespTab [5];

  initial begin
    bidTab   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    brespTab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    aresetn = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0;
    m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;

    #3;
    checkOutput("rst s_awready", s_awready, 0);
    checkOutput("rst s_wready", s_wready, 0);
    checkOutput("rst m_bready", m_bready, 0);
    checkOutput("rst valids", {m_awvalid, m_wvalid, s_bvalid}, 0);
    checkOutput("rst empties", {aw_rd_empty, w_rd_empty, b_rd_empty}, 3'b111);
    checkOutput("rst fulls", {aw_wr_full, w_wr_full, b_wr_full}, 0);
    checkOutput("rst outstanding", outstanding, 0);
    #9 aresetn = 1'b1;
    applyStimulus(1);
    checkOutput("post-rst readies", {s_awready, s_wready, m_bready}, 3'b111);

    $display("[TB] single beat");
    s_awvalid = 1'b1; s_awaddr = 32'h1000; s_awlen = 8'd0; s_awsize = 3'd3; s_awburst = 2'd1;
    s_awid = 1'b0;
    s_wvalid = 1'b1; s_wdata = {8{8'hA5}}; s_wstrb = 8'hFF; s_wlast = 1'b1;
    checkOutput("m_awvalid before hs", m_awvalid, 0);
    applyStimulus(1);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checkOutput("m_awvalid after hs", m_awvalid, 1);
    checkOutput("m_aw payload", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst},
                {1'b0, 32'h1000, 8'd0, 3'd3, 2'd1});
    checkOutput("m_wvalid after hs", m_wvalid, 1);
    checkOutput("m_w payload", {m_wdata, m_wstrb, m_wlast}, {{8{8'hA5}}, 8'hFF, 1'b1});
    checkOutput("outstanding 1", outstanding, 1);
    m_awready = 1'b1; m_wready = 1'b1;
    applyStimulus(1);
    m_awready = 1'b0; m_wready = 1'b0;
    checkOutput("aw/w drained", {m_awvalid, m_wvalid, aw_rd_empty, w_rd_empty}, 4'b0011);
    m_bvalid = 1'b1; m_bid = 1'b0; m_bresp = 2'd0;
    checkOutput("s_bvalid before push", s_bvalid, 0);
    applyStimulus(1);
    m_bvalid = 1'b0;
    checkOutput("s_bvalid after push", s_bvalid, 1);
    checkOutput("s_b payload", {s_bid, s_bresp}, 3'b000);
    checkOutput("outstanding held", outstanding, 1);
    s_bready = 1'b1;
    applyStimulus(1);
    s_bready = 1'b0;
    checkOutput("s_bvalid after pop", s_bvalid, 0);
    checkOutput("outstanding 0", outstanding, 0);

    $display("[TB] W fill and drain");
    for (int i = 0; i < 16; i++) begin
      b8 = 8'(i);
      s_wvalid = 1'b1; s_wdata = {8{b8}}; s_wstrb = b8; s_wlast = (i == 15);
      checkOutput("fill s_wready", s_wready, 1);
      applyStimulus(1);
    end
    s_wvalid = 1'b0;
    checkOutput("w full", w_wr_full, 1);
    checkOutput("w full s_wready", s_wready, 0);
    m_wready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b8 = 8'(i);
      checkOutput("drain m_wvalid", m_wvalid, 1);
      checkOutput("drain payload", {m_wdata, m_wstrb, m_wlast}, {{8{b8}}, b8, (i == 15)});
      applyStimulus(1);
      if (i == 0) checkOutput("s_wready after first pop", s_wready, 1);
    end
    m_wready = 1'b0;
    checkOutput("w empty after drain", {w_rd_empty, m_wvalid}, 2'b10);

    $display("[TB] outstanding throttle");
    m_awready = 1'b1; s_awvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_awaddr = 32'h2000 + 32'(i * 64);
      checkOutput("aw accept", s_awready, 1);
      applyStimulus(1);
    end
    checkOutput("outstanding at max", outstanding, 8);
    checkOutput("s_awready at max", s_awready, 0);
    applyStimulus(1);
    checkOutput("9th aw stalled", outstanding, 8);
    m_bvalid = 1'b1; m_bid = 1'b0; m_bresp = 2'd0;
    applyStimulus(2);
    m_bvalid = 1'b0;
    s_bready = 1'b1;
    applyStimulus(1);
    checkOutput("after one b", outstanding, 7);
    checkOutput("s_awready re-enabled", s_awready, 1);
    applyStimulus(1);
    checkOutput("aw+b simultaneous", outstanding, 7);
    s_bready = 1'b0;
    applyStimulus(1);
    s_awvalid = 1'b0;
    checkOutput("outstanding back to max", outstanding, 8);
    checkOutput("s_awready at max again", s_awready, 0);
    checkOutput("b empty", b_rd_empty, 1);

    $display("[TB] full with simultaneous pop");
    for (int i = 0; i < 4; i++) begin
      m_bvalid = 1'b1; m_bid = bidTab[i]; m_bresp = brespTab[i];
      applyStimulus(1);
    end
    checkOutput("b full (4)", b_wr_full, 1);
    checkOutput("m_bready when full", m_bready, 0);
    m_bid = bidTab[4]; m_bresp = brespTab[4];
    s_bready = 1'b1;
    applyStimulus(1);
    s_bready = 1'b0;
    checkOutput("b occupancy 3", {b_wr_full, m_bready}, 2'b01);
    checkOutput("b head after pop", {s_bvalid, s_bid, s_bresp}, {1'b1, bidTab[1], brespTab[1]});
    applyStimulus(1);
    m_bvalid = 1'b0;
    checkOutput("b occupancy 4 again", b_wr_full, 1);
    s_bready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checkOutput("b order", {s_bvalid, s_bid, s_bresp}, {1'b1, bidTab[i], brespTab[i]});
      applyStimulus(1);
    end
    s_bready = 1'b0;
    checkOutput("b empty after drain", b_rd_empty, 1);
    checkOutput("outstanding after b drain", outstanding, 3);

    $display("[TB] reset mid-burst");
    s_wvalid = 1'b1; s_wlast = 1'b0; s_wstrb = 8'hFF;
    s_wdata = 64'h1111_1111_1111_1111;
    applyStimulus(1);
    s_wdata = 64'h2222_2222_2222_2222;
    applyStimulus(1);
    s_wvalid = 1'b0;
    checkOutput("2 beats buffered", m_wvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("valids drop in reset", {m_awvalid, m_wvalid, s_bvalid}, 0);
    checkOutput("empties in reset", {aw_rd_empty, w_rd_empty, b_rd_empty}, 3'b111);
    checkOutput("outstanding cleared", outstanding, 0);
    checkOutput("s_wready in reset", s_wready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    applyStimulus(1);
    checkOutput("s_wready after release", s_wready, 1);
    m_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("nothing emitted after reset", m_wvalid, 0);
      applyStimulus(1);
    end
    m_wready = 1'b0;

    $display("[TB] throttled W scoreboard");
    sent = 0; rcvd = 0; prevHold = 1'b0; prevData = '0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (!s_wvalid && sent < NRAND && $urandom_range(0, 3) != 0) begin
        s_wvalid = 1'b1;
        s_wdata  = {$urandom, $urandom};
        s_wstrb  = 8'($urandom);
        s_wlast  = 1'($urandom);
      end
      m_wready = ($urandom_range(0, 2) != 0);
      doPush = s_wvalid && s_wready;
      doPop  = m_wvalid && m_wready;
      if (prevHold) begin
        checkOutput("stable valid", m_wvalid, 1);
        checkOutput("stable payload", {m_wdata, m_wstrb, m_wlast}, prevData);
      end
      if (m_wvalid) begin
        if (q.size() == 0) checkOutput("unexpected beat", 1, 0);
        else if (doPop) begin
          beat = q.pop_front();
          checkOutput("scoreboard", {m_wdata, m_wstrb, m_wlast}, beat);
          rcvd++;
        end
      end
      if (doPush) q.push_back({s_wdata, s_wstrb, s_wlast});
      prevHold = m_wvalid && !m_wready;
      prevData = {m_wdata, m_wstrb, m_wlast};
      applyStimulus(1);
      if (doPush) begin
        s_wvalid = 1'b0;
        sent++;
      end
      if (rcvd == NRAND) break;
    end
    s_wvalid = 1'b0; m_wready = 1'b0;
    checkOutput("all beats received", rcvd, NRAND);
    checkOutput("w empty at end", w_rd_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
